// File: rtl/matmul_pkg.sv
// Shared types and seven-segment glyph constants for the matmul result display.
package matmul_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SHOW = 2'd1,
    ERR  = 2'd2
  } disp_state_t;

  // What a display digit should render: a hex nibble or a fixed glyph.
  typedef enum logic [2:0] {
    GLYPH_HEX   = 3'd0,
    GLYPH_BLANK = 3'd1,
    GLYPH_L     = 3'd2,
    GLYPH_D     = 3'd3,
    GLYPH_E     = 3'd4
  } glyph_t;

  // Segment patterns are {dp,g,f,e,d,c,b,a}, active-low, dp always off.
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_L     = 8'hC7;
  localparam logic [7:0] SEG_d     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational nibble/glyph to active-low seven-segment pattern.
module seg_decoder
  import matmul_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  glyph_t     i_glyph,
  output logic [7:0] o_seg
);

  // Select the hex pattern or one of the fixed status glyphs.
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_glyph)
      GLYPH_HEX: o_seg = hex_to_seg(i_nibble);
      GLYPH_L:   o_seg = SEG_L;
      GLYPH_D:   o_seg = SEG_d;
      GLYPH_E:   o_seg = SEG_E;
      default:   o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/matmul_result_display.sv
// Buffers an N*N result matrix from a valid/ready stream and shows one
// selected element (D1, hex) plus row/col/status (D0) on two scanned
// 4-digit seven-segment displays.
module matmul_result_display
  import matmul_pkg::*;
#(
  parameter int N              = 4,
  parameter int W              = 16,
  parameter int REFRESH_CYCLES = 100_000
) (
  input  logic                 CLOCK_100,
  input  logic                 reset,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic [W-1:0]         res_data,
  input  logic                 res_last,
  input  logic                 clear,
  input  logic [$clog2(N)-1:0] sel_row,
  input  logic [$clog2(N)-1:0] sel_col,
  output logic                 done,
  output logic                 error,
  output logic [7:0]           D0_SEG,
  output logic [3:0]           D0_AN,
  output logic [7:0]           D1_SEG,
  output logic [3:0]           D1_AN
);

  localparam int unsigned NE       = N * N;
  localparam int          IW       = $clog2(NE);
  localparam int          CW       = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NE - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(REFRESH_CYCLES - 1);

  disp_state_t   r_state;
  disp_state_t   w_state_nxt;
  logic [IW-1:0] r_wr_ptr;
  logic [W-1:0]  r_buf [NE];
  logic [CW-1:0] r_refresh_cnt;
  logic [1:0]    r_scan_idx;
  logic [7:0]    r_d0_seg;
  logic [7:0]    r_d1_seg;
  logic [3:0]    r_an;

  logic          w_accept;
  int unsigned   w_rd_lin;
  logic [IW-1:0] w_rd_idx;
  logic [15:0]   w_elem16;
  logic [3:0]    w_d0_nib;
  logic [3:0]    w_d1_nib;
  glyph_t        w_d0_glyph;
  glyph_t        w_d1_glyph;
  logic [7:0]    w_d0_seg;
  logic [7:0]    w_d1_seg;

  // A beat is taken only in LOAD; a simultaneous clear drops it.
  assign w_accept = res_valid && (r_state == LOAD) && !clear;

  // State register.
  always_ff @(posedge CLOCK_100 or posedge reset) begin
    if (reset) r_state <= LOAD;
    else       r_state <= w_state_nxt;
  end

  // Next-state and state-decoded outputs; ready depends on state only.
  always_comb begin
    w_state_nxt = r_state;
    res_ready   = 1'b0;
    done        = 1'b0;
    error       = 1'b0;
    case (r_state)
      LOAD: res_ready = 1'b1;
      SHOW: done      = 1'b1;
      ERR:  error     = 1'b1;
      default: ;
    endcase
    if (clear) begin
      w_state_nxt = LOAD;
    end else if (w_accept) begin
      if (r_wr_ptr == LAST_IDX) w_state_nxt = SHOW;
      else if (res_last)        w_state_nxt = ERR;
    end
  end

  // Element buffer and write pointer.
  always_ff @(posedge CLOCK_100 or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      for (int unsigned i = 0; i < NE; i++) r_buf[IW'(i)] <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
    end else if (w_accept) begin
      r_buf[r_wr_ptr] <= res_data;
      r_wr_ptr        <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + IW'(1);
    end
  end

  // Scan timing: dwell REFRESH_CYCLES per digit, then step to the next digit.
  always_ff @(posedge CLOCK_100 or posedge reset) begin
    if (reset) begin
      r_refresh_cnt <= '0;
      r_scan_idx    <= '0;
    end else if (r_refresh_cnt == CNT_MAX) begin
      r_refresh_cnt <= '0;
      r_scan_idx    <= r_scan_idx + 2'd1;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + CW'(1);
    end
  end

  // Selected element lookup, guarded against out-of-range selects for non-power-of-two N.
  always_comb begin
    w_rd_lin = 32'(sel_row) * N + 32'(sel_col);
    w_rd_idx = (w_rd_lin < NE) ? IW'(w_rd_lin) : '0;
    w_elem16 = 16'(r_buf[w_rd_idx]);
  end

  // Per-digit content for both displays from the shared scan index.
  always_comb begin
    w_d0_nib   = 4'h0;
    w_d0_glyph = GLYPH_BLANK;
    w_d1_nib   = w_elem16[{r_scan_idx, 2'b00} +: 4];
    w_d1_glyph = (r_state == SHOW) ? GLYPH_HEX : GLYPH_BLANK;
    case (r_scan_idx)
      2'd3: begin
        w_d0_nib   = 4'(sel_row);
        w_d0_glyph = GLYPH_HEX;
      end
      2'd2: begin
        w_d0_nib   = 4'(sel_col);
        w_d0_glyph = GLYPH_HEX;
      end
      2'd1: w_d0_glyph = GLYPH_BLANK;
      default: begin
        case (r_state)
          SHOW:    w_d0_glyph = GLYPH_D;
          ERR:     w_d0_glyph = GLYPH_E;
          default: w_d0_glyph = GLYPH_L;
        endcase
      end
    endcase
  end

  seg_decoder u_dec_d0 (
    .i_nibble (w_d0_nib),
    .i_glyph  (w_d0_glyph),
    .o_seg    (w_d0_seg)
  );

  seg_decoder u_dec_d1 (
    .i_nibble (w_d1_nib),
    .i_glyph  (w_d1_glyph),
    .o_seg    (w_d1_seg)
  );

  // Segments and anodes register on the same edge so a digit never shows neighbour data.
  always_ff @(posedge CLOCK_100 or posedge reset) begin
    if (reset) begin
      r_d0_seg <= SEG_BLANK;
      r_d1_seg <= SEG_BLANK;
      r_an     <= '1;
    end else begin
      r_d0_seg <= w_d0_seg;
      r_d1_seg <= w_d1_seg;
      r_an     <= ~(4'b0001 << r_scan_idx);
    end
  end

  assign D0_SEG = r_d0_seg;
  assign D1_SEG = r_d1_seg;
  assign D0_AN  = r_an;
  assign D1_AN  = r_an;

endmodule
